food_manager: RTL and testbench
===============================

# food_manager

Food manager for the snake game. It owns the food pellet and the snake length. It watches the head position the snake logic reports, detects when the head lands on the pellet, and grows the length that feeds back into the snake logic. It then places a new pellet at a pseudo-random on-screen position and issues a one-pixel plot request for it toward the VGA plot path.

## Interface
- FOOD_COLOUR, 3'b100: colour driven on `colour_out` when plotting the pellet.
- INIT_LEN, 11'd4: length after reset.
- GROW_STEP, 11'd1: length increment per pellet eaten.
- MAX_LEN, 11'd2047: length saturation value.
- LFSR_SEED, 16'hACE1: LFSR value loaded at reset; must be nonzero.

- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- food_en  in  1  one-cycle pulse from snake control: head update for this step is complete, check food now.
- head_x  in  8  current head column, 0..159.
- head_y  in  7  current head row, 0..119.
- isDead  in  1  snake dead; level, freezes growth and spawning.
- length  out  11  current snake length, fed to the snake logic.
- food_x  out  8  pellet column.
- food_y  out  7  pellet row.
- ate  out  1  one-cycle pulse when a pellet is eaten.
- x  out  8  plot column.
- y  out  7  plot row.
- colour_out  out  3  plot colour.
- plotEn  out  1  plot strobe; one pixel per high cycle.

## Operation
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances every clock, including in IDLE.
- Candidate column `cx`: take v = lfsr[7:0]. `cx` = v−160 if v ≥ 160, else v.
- Candidate row `cy`: take w = lfsr[14:8]. `cy` = w−120 if w ≥ 120, else w.
- The candidate is always on screen.
- FSM states:
  - SPAWN: latch `food_x`/`food_y` ← `cx`/`cy`; go to DRAW.
  - DRAW: `plotEn`=1, `x`=`food_x`, `y`=`food_y`, `colour_out`=FOOD_COLOUR; go to IDLE.
  - IDLE: wait for `food_en`=1 with `isDead`=0, then go to CHECK. `food_en` while `isDead`=1 is ignored.
  - CHECK: compare `head_x`==`food_x` and `head_y`==`food_y`.
    - Match: `length` ← min(`length`+GROW_STEP, MAX_LEN); `ate`=1 for this cycle; go to SPAWN.
    - No match: go to IDLE.
- Width rules:
  - The addition is done in 12 bits, then saturated to MAX_LEN.
  - `length` never wraps.
  - `ate` still pulses when `length` is already at MAX_LEN.
- Outside DRAW: `plotEn`=0, and `x`/`y`/`colour_out` hold their last values.
- `isDead` rising while in CHECK, SPAWN or DRAW: the in-flight sequence completes, then the FSM parks in IDLE.
- `food_en` while not in IDLE is dropped, not queued.

## Timing
- Reset values:
  - FSM = SPAWN.
  - `length`=INIT_LEN.
  - `food_x`=0, `food_y`=0.
  - `ate`=0, `plotEn`=0.
  - `x`=0, `y`=0, `colour_out`=0.
  - LFSR=LFSR_SEED.
- After reset release:
  - Cycle 1: SPAWN.
  - Cycle 2: DRAW, with `plotEn` high exactly one cycle.
  - Cycle 3: IDLE.
- `food_en` is sampled at edge N while in IDLE; CHECK is active in cycle N+1.
- On a hit:
  - `ate` and the new `length` are visible in cycle N+1.
  - SPAWN runs in N+2; the new `food_x`/`food_y` are visible from N+3.
  - DRAW is in N+3 (`plotEn`=1); IDLE is in N+4.
- Hit to new-pellet plot: 3 cycles. Check of a miss: 1 cycle back to IDLE.
- `head_x`/`head_y` must be stable in the cycle after the `food_en` pulse.
- Reset asserted mid-sequence: all outputs return to reset values immediately (asynchronous). Any pending grow is lost.

## Configuration
- FOOD_AVOID_HEAD_EN:
  - Defined: in SPAWN, if `cx`==`head_x` and `cy`==`head_y`, stay in SPAWN and retry with the next LFSR value. DRAW is entered only with a non-colliding position. Spawn latency grows by one cycle per retry.
  - Undefined: SPAWN always accepts the first candidate and takes exactly one cycle.

## Test plan
- Reset release, LFSR_SEED=16'hACE1:
  - `length`=4.
  - `plotEn` high for exactly one cycle at cycle 2, with `x`/`y` equal to `food_x`/`food_y`, both on screen, and `colour_out`=3'b100.
- Force head onto the pellet and pulse `food_en`:
  - `ate`=1 and `length`=5 one cycle later.
  - New pellet plotted 3 cycles after the check.
- Head off the pellet, pulse `food_en`: `ate` stays 0, `length` unchanged, no `plotEn`, FSM back in IDLE after 1 cycle.
- `isDead`=1, head on the pellet, pulse `food_en`: no `ate`, `length` unchanged, no plot.
- Preload `length` to 2047 via INIT_LEN=2047, then eat: `ate`=1, `length` stays 2047.
- With FOOD_AVOID_HEAD_EN defined, drive head to the candidate position: SPAWN repeats, and the plotted pellet never equals the head position. Also assert `rst` mid-DRAW: `plotEn` drops to 0 and `length`=INIT_LEN immediately.

Source files
------------

// File: rtl/food_manager.sv
// -----------------------------------------------------------------------------
// food_manager
//
// Owns the snake-game food pellet and the snake length. When snake control
// pulses food_en (head update for this step is complete), the head position
// is compared with the pellet. On a hit the length grows (saturating at
// MAX_LEN), ate pulses, and a new pellet is placed at a pseudo-random
// on-screen position taken from a free-running 16-bit LFSR. The new pellet is
// then plotted as one pixel toward the VGA plot path.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   food_en     one-cycle "check food now" pulse from snake control
//   head_x/y    current head column (0..159) / row (0..119)
//   isDead      snake dead (level); freezes growth and spawning
//   length      current snake length
//   food_x/y    pellet column / row
//   ate         one-cycle pulse when a pellet is eaten
//   x/y         plot column / row
//   colour_out  plot colour
//   plotEn      plot strobe, one pixel per high cycle
//
// Build option:
//   FOOD_AVOID_HEAD_EN  when defined, a spawn candidate equal to the head
//                       position is rejected and SPAWN retries with the
//                       next LFSR value.
// -----------------------------------------------------------------------------
module food_manager #(
    parameter logic [2:0]  FOOD_COLOUR = 3'b100,
    parameter logic [10:0] INIT_LEN    = 11'd4,
    parameter logic [10:0] GROW_STEP   = 11'd1,
    parameter logic [10:0] MAX_LEN     = 11'd2047,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        food_en,
    input  logic [7:0]  head_x,
    input  logic [6:0]  head_y,
    input  logic        isDead,
    output logic [10:0] length,
    output logic [7:0]  food_x,
    output logic [6:0]  food_y,
    output logic        ate,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour_out,
    output logic        plotEn
);

    localparam logic [1:0] ST_SPAWN = 2'd0;
    localparam logic [1:0] ST_DRAW  = 2'd1;
    localparam logic [1:0] ST_IDLE  = 2'd2;
    localparam logic [1:0] ST_CHECK = 2'd3;

    logic [1:0]  state_r;
    logic [15:0] lfsr_r;
    logic [10:0] length_r;
    logic [7:0]  food_x_r;
    logic [6:0]  food_y_r;
    logic        ate_r;
    logic [7:0]  x_r;
    logic [6:0]  y_r;
    logic [2:0]  colour_r;
    logic        plot_en_r;

    logic [7:0]  cand_v_s;
    logic [6:0]  cand_w_s;
    logic [7:0]  cx_s;
    logic [6:0]  cy_s;
    logic        hit_s;
    logic [11:0] sum_s;
    logic [10:0] grown_s;
    logic        spawn_ok_s;

    // Fibonacci LFSR step, taps 16,14,13,11 (bits 15,13,12,10), shift left.
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        return {cur[14:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
    endfunction

    // Candidate position folding, hit detect and saturating growth.
    always_comb begin
        cand_v_s = lfsr_r[7:0];
        cand_w_s = lfsr_r[14:8];
        // v < 256 and w < 128, so a single subtraction always lands on screen.
        if (cand_v_s >= 8'd160) begin
            cx_s = cand_v_s - 8'd160;
        end else begin
            cx_s = cand_v_s;
        end
        if (cand_w_s >= 7'd120) begin
            cy_s = cand_w_s - 7'd120;
        end else begin
            cy_s = cand_w_s;
        end
        hit_s = (head_x == food_x_r) && (head_y == food_y_r);
        // 12-bit sum so the carry is visible before clamping.
        sum_s = {1'b0, length_r} + {1'b0, GROW_STEP};
        if (sum_s > {1'b0, MAX_LEN}) begin
            grown_s = MAX_LEN;
        end else begin
            grown_s = sum_s[10:0];
        end
`ifdef FOOD_AVOID_HEAD_EN
        spawn_ok_s = !((cx_s == head_x) && (cy_s == head_y));
`else
        spawn_ok_s = 1'b1;
`endif
    end

    // Free-running LFSR, advances every clock regardless of FSM state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_r <= LFSR_SEED;
        end else begin
            lfsr_r <= lfsr_step(lfsr_r);
        end
    end

    // Spawn / draw / idle / check sequencer with registered outputs.
    // The hit is evaluated on the edge that accepts food_en, so ate and the
    // grown length are already on the outputs during the CHECK cycle; CHECK
    // then only decides between SPAWN and IDLE from the registered ate.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_SPAWN;
            length_r  <= INIT_LEN;
            food_x_r  <= 8'd0;
            food_y_r  <= 7'd0;
            ate_r     <= 1'b0;
            x_r       <= 8'd0;
            y_r       <= 7'd0;
            colour_r  <= 3'd0;
            plot_en_r <= 1'b0;
        end else begin
            ate_r     <= 1'b0;
            plot_en_r <= 1'b0;
            case (state_r)
                ST_SPAWN: begin
                    if (spawn_ok_s) begin
                        food_x_r  <= cx_s;
                        food_y_r  <= cy_s;
                        x_r       <= cx_s;
                        y_r       <= cy_s;
                        colour_r  <= FOOD_COLOUR;
                        plot_en_r <= 1'b1;
                        state_r   <= ST_DRAW;
                    end
                end
                ST_DRAW: begin
                    state_r <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (food_en && !isDead) begin
                        ate_r   <= hit_s;
                        state_r <= ST_CHECK;
                        if (hit_s) begin
                            length_r <= grown_s;
                        end
                    end
                end
                ST_CHECK: begin
                    if (ate_r) begin
                        state_r <= ST_SPAWN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_SPAWN;
                end
            endcase
        end
    end

    assign length     = length_r;
    assign food_x     = food_x_r;
    assign food_y     = food_y_r;
    assign ate        = ate_r;
    assign x          = x_r;
    assign y          = y_r;
    assign colour_out = colour_r;
    assign plotEn     = plot_en_r;

endmodule

// File: tb/tb_food_manager.sv
module tb_food_manager;

    logic        clk = 1'b0;
    logic        rst;
    logic        food_en;
    logic [7:0]  head_x;
    logic [6:0]  head_y;
    logic        isDead;
    logic [10:0] length;
    logic [7:0]  food_x;
    logic [6:0]  food_y;
    logic        ate;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour_out;
    logic        plotEn;

    // second instance, preloaded at the saturation length
    logic        food_en2;
    logic [7:0]  head_x2;
    logic [6:0]  head_y2;
    logic [10:0] length2;
    logic [7:0]  food_x2;
    logic [6:0]  food_y2;
    logic        ate2;
    logic [7:0]  x2;
    logic [6:0]  y2;
    logic [2:0]  colour2;
    logic        plot_en2;

    int checks = 0;
    int errors = 0;

    // reference state
    logic [15:0] m_lfsr;
    int exp_len;
    int exp_fx, exp_fy;
    int boot_fx, boot_fy;

    typedef struct {
        bit hit;
        bit dead;
        bit exp_ate;
        int grow;
    } vec_t;
    vec_t vecs[7];

    always #5 clk = ~clk;

    food_manager dut (
        .clk(clk), .rst(rst), .food_en(food_en), .head_x(head_x), .head_y(head_y),
        .isDead(isDead), .length(length), .food_x(food_x), .food_y(food_y),
        .ate(ate), .x(x), .y(y), .colour_out(colour_out), .plotEn(plotEn)
    );

    food_manager #(.INIT_LEN(11'd2047)) dut_sat (
        .clk(clk), .rst(rst), .food_en(food_en2), .head_x(head_x2), .head_y(head_y2),
        .isDead(1'b0), .length(length2), .food_x(food_x2), .food_y(food_y2),
        .ate(ate2), .x(x2), .y(y2), .colour_out(colour2), .plotEn(plot_en2)
    );

    // Reference pseudo-random source: parity of tapped bits shifted in.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & 16'hB400)};
    endfunction

    function automatic int cand_x(input logic [15:0] s);
        return int'(s[7:0]) % 160;
    endfunction

    function automatic int cand_y(input logic [15:0] s);
        return int'(s[14:8]) % 120;
    endfunction

    // Reference LFSR tracks the DUT's sequence from reset.
    always @(posedge clk or negedge rst) begin
        if (!rst) m_lfsr <= 16'hACE1;
        else      m_lfsr <= lfsr_next(m_lfsr);
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Waits through SPAWN (and any retries) to DRAW, checking the plotted pixel.
    task automatic expect_spawn(input string tag);
        int  cx, cy;
        bit  done;
        done = 1'b0;
        for (int k = 0; k < 16 && !done; k++) begin
            cx = cand_x(m_lfsr);
            cy = cand_y(m_lfsr);
            check({tag, "_spawn_noplot"}, plotEn, 0);
            @(negedge clk);
`ifdef FOOD_AVOID_HEAD_EN
            if (cx == int'(head_x) && cy == int'(head_y)) continue;
`endif
            check({tag, "_plot_on"}, plotEn, 1);
            check({tag, "_x"}, x, cx);
            check({tag, "_y"}, y, cy);
            check({tag, "_food_x"}, food_x, cx);
            check({tag, "_food_y"}, food_y, cy);
            check({tag, "_colour"}, colour_out, 4);
            exp_fx = cx;
            exp_fy = cy;
            done = 1'b1;
        end
        if (!done) check({tag, "_spawn_timeout"}, 0, 1);
        @(negedge clk);
        check({tag, "_plot_off"}, plotEn, 0);
    endtask

    task automatic release_reset();
        rst = 1'b1;
        exp_len = 4;
        expect_spawn("boot");
        boot_fx = exp_fx;
        boot_fy = exp_fy;
        check("boot_length", length, 4);
    endtask

    // One food_en step: head on/off the pellet, dead or alive.
    task automatic do_step(input bit hit, input bit dead, input bit exp_ate,
                           input int grow, input string tag);
        int hx, hy;
        if (hit) begin
            hx = exp_fx;
            hy = exp_fy;
        end else begin
            hx = int'($urandom_range(0, 159));
            hy = int'($urandom_range(0, 119));
            if (hx == exp_fx && hy == exp_fy) hx = (hx + 1) % 160;
        end
        head_x  = 8'(hx);
        head_y  = 7'(hy);
        isDead  = dead;
        food_en = 1'b1;
        if (grow > 0) exp_len = (exp_len + grow > 2047) ? 2047 : exp_len + grow;
        @(negedge clk);
        food_en = 1'b0;
        check({tag, "_ate"}, ate, exp_ate);
        check({tag, "_length"}, length, exp_len);
        if (exp_ate) begin
            @(negedge clk);
            check({tag, "_ate_pulse_end"}, ate, 0);
            expect_spawn(tag);
        end else begin
            check({tag, "_noplot"}, plotEn, 0);
            @(negedge clk);
            check({tag, "_noplot2"}, plotEn, 0);
            check({tag, "_ate_low"}, ate, 0);
        end
    endtask

    initial begin
        rst      = 1'b0;
        food_en  = 1'b0;
        isDead   = 1'b0;
        head_x   = 8'd0;
        head_y   = 7'd0;
        food_en2 = 1'b0;
        head_x2  = 8'd0;
        head_y2  = 7'd0;

        //            hit dead exp_ate grow
        vecs[0] = '{1'b1, 1'b0, 1'b1, 1};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 0};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 1};   // hit right after a miss: IDLE after 1 cycle
        vecs[3] = '{1'b1, 1'b1, 1'b0, 0};   // dead on the pellet
        vecs[4] = '{1'b0, 1'b1, 1'b0, 0};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 0};

        repeat (2) @(negedge clk);
        check("rst_length", length, 4);
        check("rst_plot", plotEn, 0);
        check("rst_ate", ate, 0);
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_colour", colour_out, 0);
        check("rst_food_x", food_x, 0);
        check("rst_food_y", food_y, 0);
        check("rst_sat_length", length2, 2047);

        release_reset();

        for (int i = 0; i < 7; i++) begin
            do_step(vecs[i].hit, vecs[i].dead, vecs[i].exp_ate, vecs[i].grow,
                    $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 30; i++) begin
            bit h, d, e;
            h = ($urandom_range(0, 1) == 1);
            d = ($urandom_range(0, 3) == 0);
            e = h && !d;
            do_step(h, d, e, e ? 1 : 0, $sformatf("rnd%0d", i));
        end
        isDead = 1'b0;

        // reset asserted in the middle of DRAW
        head_x  = 8'(exp_fx);
        head_y  = 7'(exp_fy);
        food_en = 1'b1;
        @(negedge clk);
        food_en = 1'b0;
        check("middraw_ate", ate, 1);
        @(negedge clk);
        @(negedge clk);
        check("middraw_plot_on", plotEn, 1);
        rst = 1'b0;
        #1;
        check("middraw_plot_off", plotEn, 0);
        check("middraw_length", length, 4);
        check("middraw_ate_low", ate, 0);
        check("middraw_x", x, 0);
        check("middraw_y", y, 0);
        check("middraw_colour", colour_out, 0);
        check("middraw_food_x", food_x, 0);
        @(negedge clk);
        release_reset();
        do_step(1'b1, 1'b0, 1'b1, 1, "post_rst");

        // saturation: length already at the maximum
        head_x2  = 8'(boot_fx);
        head_y2  = 7'(boot_fy);
        food_en2 = 1'b1;
        @(negedge clk);
        food_en2 = 1'b0;
        check("sat_ate", ate2, 1);
        check("sat_length", length2, 2047);
        repeat (4) @(negedge clk);
        check("sat_length_hold", length2, 2047);

`ifdef FOOD_AVOID_HEAD_EN
        begin
            logic [15:0] spawn_state;
            head_x  = 8'(exp_fx);
            head_y  = 7'(exp_fy);
            food_en = 1'b1;
            exp_len = exp_len + 1;
            @(negedge clk);
            food_en = 1'b0;
            check("avoid_ate", ate, 1);
            // steer the head onto the first SPAWN candidate
            spawn_state = lfsr_next(m_lfsr);
            head_x = 8'(cand_x(spawn_state));
            head_y = 7'(cand_y(spawn_state));
            @(negedge clk);
            check("avoid_first_try_collides", cand_x(m_lfsr), int'(head_x));
            @(negedge clk);
            check("avoid_retry_noplot", plotEn, 0);
            expect_spawn("avoid");
            check("avoid_not_on_head", (exp_fx == int'(head_x) && exp_fy == int'(head_y)) ? 1 : 0, 0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
